// File: rtl/ip_mul_responder.sv
// IP-side multiply responder under the bus wrapper.
// Iterative shift-add multiply of the two operand halves.
module ip_mul_responder #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              write,
  input  logic [DATA_W-1:0] IPdata_in,
  output logic [DATA_W-1:0] IPdata_out,
  output logic              ready,
  output logic              busy,
  output logic              overrun
);

  localparam int HALF = DATA_W / 2;
  localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0] LAST = CW'(HALF - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] mcand;
  logic [HALF-1:0]   mplier;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] addend;
  logic [DATA_W-1:0] acc_nxt;

  // Partial product for the current multiplier bit.
  always_comb begin
    addend  = '0;
    if (mplier[0]) addend = mcand;
    acc_nxt = acc + addend;
  end

  // Control FSM with the datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      acc        <= '0;
      mcand      <= '0;
      mplier     <= '0;
      cnt        <= '0;
      IPdata_out <= '0;
      ready      <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (write) begin
            mcand   <= {{HALF{1'b0}}, IPdata_in[DATA_W-1:HALF]};
            mplier  <= IPdata_in[HALF-1:0];
            acc     <= '0;
            cnt     <= '0;
            busy    <= 1'b1;
            ready   <= 1'b0;
            overrun <= 1'b0;
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (write) overrun <= 1'b1;
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            IPdata_out <= acc_nxt;
            ready      <= 1'b1;
            busy       <= 1'b0;
            state      <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
